// File: rtl/hwpe_csb_adapter.sv
// Bridges HWPE peripheral-slave accesses onto the NVDLA CSB port, one transaction at a time.
// A watchdog guarantees that every granted access gets exactly one response.
module hwpe_csb_adapter #(
   parameter int unsigned ID_WIDTH       = 1,
   parameter int unsigned CSB_AW         = 16,
   parameter bit          NPOSTED        = 1'b0,
   parameter int unsigned TIMEOUT_CYCLES = 1024,
   parameter logic [31:0] TIMEOUT_DATA   = 32'hDEADBEEF
) (
   input  logic                clk_i,
   input  logic                rst_ni,
   input  logic                periph_req_i,
   input  logic [31:0]         periph_add_i,
   input  logic                periph_wen_i,
   input  logic [3:0]          periph_be_i,
   input  logic [31:0]         periph_data_i,
   input  logic [ID_WIDTH-1:0] periph_id_i,
   output logic                periph_gnt_o,
   output logic [31:0]         periph_r_data_o,
   output logic                periph_r_valid_o,
   output logic [ID_WIDTH-1:0] periph_r_id_o,
   output logic                csb2nvdla_valid_o,
   input  logic                csb2nvdla_ready_i,
   output logic [CSB_AW-1:0]   csb2nvdla_addr_o,
   output logic [31:0]         csb2nvdla_wdat_o,
   output logic                csb2nvdla_write_o,
   output logic                csb2nvdla_nposted_o,
   input  logic                nvdla2csb_valid_i,
   input  logic [31:0]         nvdla2csb_data_i,
   input  logic                nvdla2csb_wr_complete_i,
   output logic                timeout_o
);

   localparam int unsigned CNT_W = (TIMEOUT_CYCLES > 1) ? $clog2(TIMEOUT_CYCLES) : 1;
   localparam logic [CNT_W-1:0] LP_CNT_LAST =
      CNT_W'((TIMEOUT_CYCLES > 0) ? TIMEOUT_CYCLES - 1 : 0);

   typedef enum logic [2:0] {
      S_IDLE,
      S_CSB_REQ,
      S_WAIT_RD,
      S_WAIT_WR,
      S_RESP
   } state_e;

   state_e              r_state;
   logic [CNT_W-1:0]    r_cnt;
   logic                r_csb_valid;
   logic [CSB_AW-1:0]   r_csb_addr;
   logic [31:0]         r_csb_wdat;
   logic                r_csb_write;
   logic                r_csb_nposted;
   logic [31:0]         r_rdata;
   logic                r_rvalid;
   logic [ID_WIDTH-1:0] r_rid;
   logic                r_timeout;

   logic                w_gnt;
   logic                w_expire;
   logic                w_unused;

   // Byte enables are meaningless on a strobe-less CSB; address bits outside the word field are dropped.
   assign w_unused = ^{periph_be_i, periph_add_i};

   assign w_gnt    = rst_ni && (r_state == S_IDLE) && periph_req_i;
   assign w_expire = (TIMEOUT_CYCLES != 0) && (r_cnt == LP_CNT_LAST);

   always_ff @(posedge clk_i or negedge rst_ni) begin
      if (!rst_ni) begin
         r_state       <= S_IDLE;
         r_cnt         <= '0;
         r_csb_valid   <= 1'b0;
         r_csb_addr    <= '0;
         r_csb_wdat    <= '0;
         r_csb_write   <= 1'b0;
         r_csb_nposted <= 1'b0;
         r_rdata       <= '0;
         r_rvalid      <= 1'b0;
         r_rid         <= '0;
         r_timeout     <= 1'b0;
      end else begin
         r_rvalid  <= 1'b0;
         r_timeout <= 1'b0;
         case (r_state)
            S_IDLE: begin
               r_cnt <= '0;
               if (periph_req_i) begin
                  r_csb_addr    <= periph_add_i[CSB_AW+1:2];
                  r_csb_wdat    <= periph_data_i;
                  r_csb_write   <= ~periph_wen_i;
                  r_csb_nposted <= ~periph_wen_i & NPOSTED;
                  r_rid         <= periph_id_i;
                  r_csb_valid   <= 1'b1;
                  r_state       <= S_CSB_REQ;
               end
            end
            S_CSB_REQ: begin
               // An accept in the expiry cycle counts as a response and wins over the watchdog.
               if (csb2nvdla_ready_i) begin
                  r_csb_valid <= 1'b0;
                  r_cnt       <= '0;
                  if (!r_csb_write) begin
                     r_state <= S_WAIT_RD;
                  end else if (NPOSTED) begin
                     r_state <= S_WAIT_WR;
                  end else begin
                     r_rdata  <= '0;
                     r_rvalid <= 1'b1;
                     r_state  <= S_RESP;
                  end
               end else if (w_expire) begin
                  r_csb_valid <= 1'b0;
                  r_cnt       <= '0;
                  r_rdata     <= r_csb_write ? 32'h0 : TIMEOUT_DATA;
                  r_rvalid    <= 1'b1;
                  r_timeout   <= 1'b1;
                  r_state     <= S_RESP;
               end else begin
                  r_cnt <= r_cnt + 1'b1;
               end
            end
            S_WAIT_RD: begin
               if (nvdla2csb_valid_i) begin
                  r_cnt    <= '0;
                  r_rdata  <= nvdla2csb_data_i;
                  r_rvalid <= 1'b1;
                  r_state  <= S_RESP;
               end else if (w_expire) begin
                  r_cnt     <= '0;
                  r_rdata   <= TIMEOUT_DATA;
                  r_rvalid  <= 1'b1;
                  r_timeout <= 1'b1;
                  r_state   <= S_RESP;
               end else begin
                  r_cnt <= r_cnt + 1'b1;
               end
            end
            S_WAIT_WR: begin
               if (nvdla2csb_wr_complete_i) begin
                  r_cnt    <= '0;
                  r_rdata  <= '0;
                  r_rvalid <= 1'b1;
                  r_state  <= S_RESP;
               end else if (w_expire) begin
                  r_cnt     <= '0;
                  r_rdata   <= '0;
                  r_rvalid  <= 1'b1;
                  r_timeout <= 1'b1;
                  r_state   <= S_RESP;
               end else begin
                  r_cnt <= r_cnt + 1'b1;
               end
            end
            S_RESP: begin
               r_cnt   <= '0;
               r_state <= S_IDLE;
            end
            default: begin
               r_cnt   <= '0;
               r_state <= S_IDLE;
            end
         endcase
      end
   end

   assign periph_gnt_o        = w_gnt;
   assign periph_r_data_o     = r_rdata;
   assign periph_r_valid_o    = r_rvalid;
   assign periph_r_id_o       = r_rid;
   assign csb2nvdla_valid_o   = r_csb_valid;
   assign csb2nvdla_addr_o    = r_csb_addr;
   assign csb2nvdla_wdat_o    = r_csb_wdat;
   assign csb2nvdla_write_o   = r_csb_write;
   assign csb2nvdla_nposted_o = r_csb_nposted;
   assign timeout_o           = r_timeout;

endmodule

// File: tb/tb_hwpe_csb_adapter.sv
// Bench for hwpe_csb_adapter: vector table, directed multi-cycle sequences and a random run
// scored against a latency/data model derived from the transaction rules.
module tb_hwpe_csb_adapter;

   localparam int TO = 16;

   logic        clk = 1'b0;
   logic        rst_n = 1'b1;
   logic        req = 1'b0;
   logic [31:0] p_add = '0;
   logic        p_wen = 1'b0;
   logic [3:0]  p_be = '0;
   logic [31:0] p_wdat = '0;
   logic [0:0]  p_id = '0;
   logic        ready = 1'b0;
   logic        nvv = 1'b0;
   logic [31:0] nvdata = '0;
   logic        wrc = 1'b0;

   logic        gnt0, rvalid0, cv0, write0, np0, to0;
   logic [31:0] rdata0, wdat0;
   logic [0:0]  rid0;
   logic [15:0] addr0;
   logic        gnt1, rvalid1, cv1, write1, np1, to1;
   logic [31:0] rdata1, wdat1;
   logic [0:0]  rid1;
   logic [15:0] addr1;

   int n_pass = 0;
   int n_total = 0;

   always #5 clk = ~clk;

   hwpe_csb_adapter #(.ID_WIDTH(1), .CSB_AW(16), .NPOSTED(1'b0), .TIMEOUT_CYCLES(TO),
                      .TIMEOUT_DATA(32'hDEADBEEF)) dut0 (
      .clk_i(clk), .rst_ni(rst_n), .periph_req_i(req), .periph_add_i(p_add),
      .periph_wen_i(p_wen), .periph_be_i(p_be), .periph_data_i(p_wdat), .periph_id_i(p_id),
      .periph_gnt_o(gnt0), .periph_r_data_o(rdata0), .periph_r_valid_o(rvalid0),
      .periph_r_id_o(rid0), .csb2nvdla_valid_o(cv0), .csb2nvdla_ready_i(ready),
      .csb2nvdla_addr_o(addr0), .csb2nvdla_wdat_o(wdat0), .csb2nvdla_write_o(write0),
      .csb2nvdla_nposted_o(np0), .nvdla2csb_valid_i(nvv), .nvdla2csb_data_i(nvdata),
      .nvdla2csb_wr_complete_i(wrc), .timeout_o(to0));

   hwpe_csb_adapter #(.ID_WIDTH(1), .CSB_AW(16), .NPOSTED(1'b1), .TIMEOUT_CYCLES(TO),
                      .TIMEOUT_DATA(32'hDEADBEEF)) dut1 (
      .clk_i(clk), .rst_ni(rst_n), .periph_req_i(req), .periph_add_i(p_add),
      .periph_wen_i(p_wen), .periph_be_i(p_be), .periph_data_i(p_wdat), .periph_id_i(p_id),
      .periph_gnt_o(gnt1), .periph_r_data_o(rdata1), .periph_r_valid_o(rvalid1),
      .periph_r_id_o(rid1), .csb2nvdla_valid_o(cv1), .csb2nvdla_ready_i(ready),
      .csb2nvdla_addr_o(addr1), .csb2nvdla_wdat_o(wdat1), .csb2nvdla_write_o(write1),
      .csb2nvdla_nposted_o(np1), .nvdla2csb_valid_i(nvv), .nvdla2csb_data_i(nvdata),
      .nvdla2csb_wr_complete_i(wrc), .timeout_o(to1));

   typedef struct {
      logic        wen;
      logic [31:0] add;
      logic [31:0] data;
      logic [3:0]  be;
      logic        id;
      int          k;       // cycles csb valid waits before ready
      int          j;       // cycles in WAIT_RD before read data arrives
      logic [31:0] rd;
      logic [15:0] e_addr;
      logic [31:0] e_rdata;
      int          e_lat;   // grant-to-r_valid cycles
      logic        e_to;
   } vec_t;

   task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
      n_total++;
      if (act === exp) n_pass++;
      else $display("FAIL %s: got 0x%08h, expected 0x%08h", nm, act, exp);
   endtask

   // Reference: response time and data from the handshake delays (posted-write adapter).
   function automatic void model(input logic wen, input int k, input int j, input logic [31:0] rd,
                                 output int lat, output logic to, output logic [31:0] rdata);
      if (k >= TO) begin
         lat = 1 + TO; to = 1'b1; rdata = wen ? 32'hDEADBEEF : 32'h0;
      end else if (!wen) begin
         lat = 2 + k; to = 1'b0; rdata = 32'h0;
      end else if (j >= TO) begin
         lat = 2 + k + TO; to = 1'b1; rdata = 32'hDEADBEEF;
      end else begin
         lat = 3 + k + j; to = 1'b0; rdata = rd;
      end
   endfunction

   task automatic run_txn(input string nm, input vec_t v);
      int tend, nvalid, nrv, nto, first_rv;
      logic fields_ok;
      logic [31:0] got_rdata;
      logic got_id;
      nvalid = 0; nrv = 0; nto = 0; first_rv = -1; fields_ok = 1'b1;
      got_rdata = '0; got_id = 1'b0;
      tend = (v.e_lat > 2 + v.k + v.j) ? v.e_lat + 2 : 4 + v.k + v.j;
      @(posedge clk); #1;
      req = 1'b1; p_add = v.add; p_wen = v.wen; p_be = v.be; p_wdat = v.data; p_id = v.id;
      ready = 1'b0; nvv = 1'b0; wrc = 1'b0;
      @(negedge clk);
      chk({nm, "/gnt"}, 32'(gnt0), 32'd1);
      for (int t = 1; t <= tend; t++) begin
         @(posedge clk); #1;
         req = 1'b0; p_add = $urandom; p_wdat = $urandom; p_wen = 1'($urandom);
         p_be = 4'($urandom); p_id = 1'($urandom);
         ready = (t == 1 + v.k);
         nvv = v.wen && (t == 2 + v.k + v.j);
         nvdata = (t == 2 + v.k + v.j) ? v.rd : $urandom;
         @(negedge clk);
         if (cv0) begin
            nvalid++;
            if (addr0 !== v.e_addr || wdat0 !== v.data || write0 !== !v.wen || np0 !== 1'b0)
               fields_ok = 1'b0;
         end
         if (to0) nto++;
         if (rvalid0) begin
            nrv++;
            if (first_rv < 0) begin
               first_rv = t; got_rdata = rdata0; got_id = rid0;
            end
         end
      end
      chk({nm, "/csb_valid_cycles"}, 32'(nvalid), 32'((v.k + 1 < TO) ? v.k + 1 : TO));
      chk({nm, "/csb_fields"}, 32'(fields_ok), 32'd1);
      chk({nm, "/rvalid_latency"}, 32'(first_rv), 32'(v.e_lat));
      chk({nm, "/rvalid_count"}, 32'(nrv), 32'd1);
      chk({nm, "/rdata"}, got_rdata, v.e_rdata);
      chk({nm, "/rid"}, 32'(got_id), 32'(v.id));
      chk({nm, "/timeout"}, 32'(nto), 32'(v.e_to));
   endtask

   task automatic reset_pulse();
      @(posedge clk); #1 rst_n = 1'b0;
      repeat (2) @(posedge clk);
      #1 rst_n = 1'b1;
   endtask

   // Requests held high for three accesses: grants only in IDLE, ordered responses.
   task automatic back_to_back();
      logic        a_wen [3];
      logic [31:0] a_add [3];
      logic        a_id  [3];
      int gi, ri, gcyc[3], rcyc[3];
      logic rid_a[3];
      logic [31:0] rdat_a[3];
      logic overlap, g_now;
      a_wen = '{1'b0, 1'b1, 1'b0};
      a_add = '{32'h100, 32'h104, 32'h108};
      a_id  = '{1'b1, 1'b0, 1'b1};
      gi = 0; ri = 0; overlap = 1'b0;
      for (int i = 0; i < 3; i++) begin
         gcyc[i] = -1; rcyc[i] = -1; rid_a[i] = 1'b0; rdat_a[i] = '0;
      end
      @(posedge clk); #1;
      ready = 1'b1; nvv = 1'b1; nvdata = 32'hCAFE0001; wrc = 1'b0;
      req = 1'b1; p_wen = a_wen[0]; p_add = a_add[0]; p_id = a_id[0]; p_wdat = 32'h1111;
      for (int c = 0; c <= 12; c++) begin
         @(negedge clk);
         g_now = gnt0;
         if (g_now) begin
            if (cv0) overlap = 1'b1;
            if (gi < 3) gcyc[gi] = c;
            gi++;
         end
         if (rvalid0) begin
            if (ri < 3) begin rcyc[ri] = c; rid_a[ri] = rid0; rdat_a[ri] = rdata0; end
            ri++;
         end
         @(posedge clk); #1;
         if (g_now) begin
            if (gi < 3) begin
               p_wen = a_wen[gi]; p_add = a_add[gi]; p_id = a_id[gi]; p_wdat = 32'h1111 * (gi + 1);
            end else begin
               req = 1'b0;
            end
         end
      end
      ready = 1'b0; nvv = 1'b0; req = 1'b0;
      chk("b2b/gnt_count", 32'(gi), 32'd3);
      chk("b2b/gnt_cycles", {8'(gcyc[0]), 8'(gcyc[1]), 8'(gcyc[2]), 8'd0}, {8'd0, 8'd3, 8'd7, 8'd0});
      chk("b2b/overlap", 32'(overlap), 32'd0);
      chk("b2b/rvalid_count", 32'(ri), 32'd3);
      chk("b2b/rvalid_cycles", {8'(rcyc[0]), 8'(rcyc[1]), 8'(rcyc[2]), 8'd0}, {8'd2, 8'd6, 8'd9, 8'd0});
      chk("b2b/rids", {29'd0, rid_a[0], rid_a[1], rid_a[2]}, 32'b101);
      chk("b2b/rdata0", rdat_a[0], 32'h0);
      chk("b2b/rdata1", rdat_a[1], 32'hCAFE0001);
      chk("b2b/rdata2", rdat_a[2], 32'h0);
   endtask

   // Non-posted write on the NPOSTED=1 instance; wr_complete 7 cycles after the accept.
   task automatic nonposted_write();
      int first_rv;
      logic [31:0] got_rdata;
      logic got_id, got_to;
      first_rv = -1; got_rdata = '0; got_id = 1'b0; got_to = 1'b0;
      reset_pulse();
      @(posedge clk); #1;
      req = 1'b1; p_wen = 1'b0; p_add = 32'h0000_0100; p_wdat = 32'h0000_55AA; p_id = 1'b1;
      p_be = 4'hF; ready = 1'b0; nvv = 1'b0; wrc = 1'b0;
      @(negedge clk);
      chk("npw/gnt", 32'(gnt1), 32'd1);
      for (int t = 1; t <= 12; t++) begin
         @(posedge clk); #1;
         req = 1'b0; p_wdat = $urandom;
         ready = (t == 1);
         wrc = (t == 1) || (t == 8);
         @(negedge clk);
         if (t == 1) begin
            chk("npw/csb", {cv1, write1, np1, 13'd0, addr1}, {3'b111, 13'd0, 16'h0040});
            chk("npw/wdat", wdat1, 32'h0000_55AA);
         end
         if (rvalid1 && first_rv < 0) begin
            first_rv = t; got_rdata = rdata1; got_id = rid1; got_to = to1;
         end
      end
      wrc = 1'b0; ready = 1'b0;
      chk("npw/rvalid_latency", 32'(first_rv), 32'd9);
      chk("npw/resp", {got_rdata[30:0], got_id}, 32'h1);
      chk("npw/timeout", 32'(got_to), 32'd0);
   endtask

   // Reset asserted while a read waits for data.
   task automatic reset_mid_read();
      int nrv;
      vec_t v;
      nrv = 0;
      @(posedge clk); #1;
      req = 1'b1; p_wen = 1'b1; p_add = 32'h0000_0ABC; p_id = 1'b1; ready = 1'b0; nvv = 1'b0;
      @(posedge clk); #1 req = 1'b0; ready = 1'b1;
      @(posedge clk); #1 ready = 1'b0;
      @(posedge clk); #2 rst_n = 1'b0;
      #1;
      chk("rst_mid/ctrl", {26'd0, cv0, rvalid0, to0, write0, np0, gnt0}, 32'd0);
      chk("rst_mid/addr_id", {15'd0, rid0, addr0}, 32'd0);
      chk("rst_mid/rdata", rdata0, 32'd0);
      chk("rst_mid/wdat", wdat0, 32'd0);
      @(posedge clk); #1 nvv = 1'b1; nvdata = 32'h5555_AAAA;
      @(posedge clk); #1 rst_n = 1'b1;
      for (int t = 0; t < 4; t++) begin
         @(negedge clk);
         if (rvalid0) nrv++;
      end
      nvv = 1'b0;
      chk("rst_mid/no_rvalid", 32'(nrv), 32'd0);
      v = '{1'b1, 32'h0000_0030, 32'h0, 4'h0, 1'b0, 1, 2, 32'h600D_CAFE,
            16'h000C, 32'h600D_CAFE, 6, 1'b0};
      run_txn("rst_mid/after", v);
   endtask

   initial begin
      vec_t vecs[9];
      vec_t v;
      #1 rst_n = 1'b0;
      repeat (3) @(posedge clk);
      @(negedge clk);
      chk("reset/ctrl", {26'd0, cv0, rvalid0, to0, write0, np0, gnt0}, 32'd0);
      chk("reset/addr_id", {15'd0, rid0, addr0}, 32'd0);
      chk("reset/rdata", rdata0, 32'd0);
      chk("reset/wdat", wdat0, 32'd0);
      @(posedge clk); #1 rst_n = 1'b1;

      //           wen   add            data           be     id    k   j   rd             e_addr    e_rdata        lat e_to
      vecs[0] = '{1'b0, 32'h0000_5004, 32'hA5A5_0001, 4'hF, 1'b0, 0,  0,  32'h0,         16'h1401, 32'h0,         2,  1'b0};
      vecs[1] = '{1'b1, 32'h0000_0010, 32'h0,         4'h0, 1'b1, 5,  1,  32'h1234_5678, 16'h0004, 32'h1234_5678, 9,  1'b0};
      vecs[2] = '{1'b1, 32'h0000_0020, 32'h0,         4'hF, 1'b1, 0,  30, 32'h1111_1111, 16'h0008, 32'hDEAD_BEEF, 18, 1'b1};
      vecs[3] = '{1'b1, 32'h0000_0024, 32'h0,         4'h3, 1'b0, 0,  0,  32'h0BAD_F00D, 16'h0009, 32'h0BAD_F00D, 3,  1'b0};
      vecs[4] = '{1'b0, 32'hFFFF_FFFF, 32'h0102_0304, 4'h5, 1'b1, 2,  0,  32'h0,         16'hFFFF, 32'h0,         4,  1'b0};
      vecs[5] = '{1'b0, 32'h0000_0040, 32'h0A0B_0C0D, 4'hF, 1'b0, 20, 0,  32'h0,         16'h0010, 32'h0,         17, 1'b1};
      vecs[6] = '{1'b0, 32'h0000_0044, 32'h0000_0044, 4'h1, 1'b1, 15, 0,  32'h0,         16'h0011, 32'h0,         17, 1'b0};
      vecs[7] = '{1'b1, 32'h0003_0008, 32'h0,         4'h0, 1'b0, 1,  15, 32'h0000_0077, 16'hC002, 32'h0000_0077, 19, 1'b0};
      vecs[8] = '{1'b1, 32'h0000_0008, 32'h0,         4'hF, 1'b1, 16, 0,  32'h9999_9999, 16'h0002, 32'hDEAD_BEEF, 17, 1'b1};
      for (int i = 0; i < 9; i++) run_txn($sformatf("vec%0d", i), vecs[i]);

      back_to_back();

      for (int i = 0; i < 30; i++) begin
         v.wen  = 1'($urandom_range(0, 1));
         v.add  = $urandom;
         v.data = $urandom;
         v.be   = 4'($urandom);
         v.id   = 1'($urandom);
         v.k    = ($urandom_range(0, 3) == 0) ? $urandom_range(12, 19) : $urandom_range(0, 3);
         v.j    = ($urandom_range(0, 3) == 0) ? $urandom_range(12, 19) : $urandom_range(0, 3);
         v.rd   = $urandom;
         v.e_addr = v.add[17:2];
         model(v.wen, v.k, v.j, v.rd, v.e_lat, v.e_to, v.e_rdata);
         run_txn($sformatf("rnd%0d", i), v);
      end

      nonposted_write();
      reset_mid_read();

      $display("%0d/%0d checks passed", n_pass, n_total);
      $finish;
   end

   initial begin
      #500000;
      $display("FAIL global_time_limit: got no completion, expected finish before 500000");
      $fatal(1);
   end

endmodule
